// File: rtl/io_map_pkg.sv
// Shared address map for the IO decoder: region bounds and region index type.
package io_map_pkg;

  localparam int unsigned MAP_N        = 5;
  localparam int unsigned MAP_AW       = 32;
  localparam int unsigned REGION_IDX_W = $clog2(MAP_N);

  typedef logic [REGION_IDX_W-1:0] region_idx_t;

  // Inclusive bounds; entry 0 is region 0.
  localparam logic [MAP_AW-1:0] REG_BASE [MAP_N] = '{
    32'd0, 32'd100, 32'd116, 32'd120, 32'd160120
  };
  localparam logic [MAP_AW-1:0] REG_LIMIT [MAP_N] = '{
    32'd96, 32'd100, 32'd116, 32'd160119, 32'd320120
  };

endpackage

// File: rtl/btn_capture.sv
// Two-flop synchroniser plus rising-edge detect for the push buttons.
module btn_capture #(
  parameter int unsigned BTN_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BTN_N-1:0] btn_raw,
  output logic [BTN_N-1:0] btn_rise_c
);

  logic [BTN_N-1:0] sync_q1;
  logic [BTN_N-1:0] sync_q2;
  logic [BTN_N-1:0] prev_q;

  // Synchroniser chain and previous-level register for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      prev_q  <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign btn_rise_c = sync_q2 & ~prev_q;

endmodule

// File: rtl/io_map_ctrl.sv
// IO address decoder: region selects, one-cycle read return, fault tracking
// and sticky button capture behind a status word.
module io_map_ctrl
  import io_map_pkg::*;
#(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_REG    = 5,
  parameter int unsigned BTN_N    = 4,
  parameter int unsigned BTN_ADDR = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    re,
  input  logic                    we,
  input  logic [N_REG*DATA_W-1:0] region_rdata,
  input  logic [BTN_N-1:0]        btn_raw,
  output logic [N_REG-1:0]        region_sel,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rvalid,
  output logic                    fault,
  output logic [15:0]             fault_count,
  output logic [BTN_N-1:0]        btn_pending
);

  localparam int unsigned CMP_W     = (ADDR_W > MAP_AW) ? ADDR_W : MAP_AW;
  localparam int unsigned BTN_IDX_W = (BTN_N > 1) ? $clog2(BTN_N) : 1;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  logic                 access_c;
  logic                 btn_hit_c;
  logic                 hit_any_c;
  region_idx_t          hit_idx_c;
  logic                 map_miss_c;
  logic [DATA_W-1:0]    region_word_c;
  logic [DATA_W-1:0]    btn_word_c;
  logic [BTN_IDX_W-1:0] btn_low_idx_c;
  logic [BTN_N-1:0]     btn_rise_c;
  logic [BTN_N-1:0]     btn_clr_c;

  assign access_c   = re | we;
  assign btn_hit_c  = (addr == ADDR_W'(BTN_ADDR));
  assign map_miss_c = ~btn_hit_c & ~hit_any_c;

  // Range match per region; iterating downward leaves the lowest index winning.
  always_comb begin
    hit_any_c = 1'b0;
    hit_idx_c = '0;
    for (int i = int'(N_REG) - 1; i >= 0; i--) begin
      if ((CMP_W'(addr) >= CMP_W'(REG_BASE[i])) &&
          (CMP_W'(addr) <= CMP_W'(REG_LIMIT[i]))) begin
        hit_any_c = 1'b1;
        hit_idx_c = region_idx_t'(i);
      end
    end
  end

  // One-hot enable; the button status word shadows any region at its address.
  always_comb begin
    region_sel = '0;
    for (int i = 0; i < int'(N_REG); i++) begin
      region_sel[i] = access_c & hit_any_c & ~btn_hit_c &
                      (hit_idx_c == region_idx_t'(i));
    end
  end

  // Slice of the packed read bus belonging to the hit region.
  always_comb begin
    region_word_c = '0;
    for (int i = 0; i < int'(N_REG); i++) begin
      if (hit_idx_c == region_idx_t'(i)) begin
        region_word_c = region_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Lowest set pending bit for the status word.
  always_comb begin
    btn_low_idx_c = '0;
    for (int i = int'(BTN_N) - 1; i >= 0; i--) begin
      if (btn_pending[i]) begin
        btn_low_idx_c = BTN_IDX_W'(i);
      end
    end
  end

  assign btn_word_c = DATA_W'({(|btn_pending), btn_low_idx_c, btn_pending});
  assign btn_clr_c  = (re && btn_hit_c) ? btn_pending : '0;

  btn_capture #(
    .BTN_N (BTN_N)
  ) u_btn_capture (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_rise_c (btn_rise_c)
  );

  // Read return: data is chosen at the capture edge and held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= re;
      if (re) begin
        if (btn_hit_c) begin
          rdata <= btn_word_c;
        end else if (hit_any_c) begin
          rdata <= region_word_c;
        end else begin
          rdata <= '0;
        end
      end
    end
  end

  // Unmapped-access pulse and saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault       <= 1'b0;
      fault_count <= '0;
    end else begin
      fault <= access_c & map_miss_c;
      if (access_c && map_miss_c && (fault_count != CNT_MAX)) begin
        fault_count <= fault_count + 16'd1;
      end
    end
  end

  // Sticky pending bits; a fresh edge beats a clear on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_pending <= '0;
    end else begin
      btn_pending <= (btn_pending & ~btn_clr_c) | btn_rise_c;
    end
  end

endmodule
